// File: rtl/pu_feeder_if.sv
// Operand stream into the feeder, plus the lane/strobe bundle it presents to the 4-lane PU.
interface pu_feeder_if #(
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_w;
    logic                     in_last;
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] a2;
    logic signed [DATA_W-1:0] a3;
    logic signed [DATA_W-1:0] a4;
    logic signed [DATA_W-1:0] w1;
    logic signed [DATA_W-1:0] w2;
    logic signed [DATA_W-1:0] w3;
    logic signed [DATA_W-1:0] w4;
    logic                     pu_valid;
    logic                     pu_last;
    logic                     res_valid;
    logic                     res_last;

    // The source/PU side of the feeder.
    modport master (
        output in_valid, in_a, in_w, in_last,
        input  in_ready, a1, a2, a3, a4, w1, w2, w3, w4,
        input  pu_valid, pu_last, res_valid, res_last
    );

    modport slave (
        input  in_valid, in_a, in_w, in_last,
        output in_ready, a1, a2, a3, a4, w1, w2, w3, w4,
        output pu_valid, pu_last, res_valid, res_last
    );
endinterface

// File: rtl/pu_feeder.sv
// Packs a serial (activation, weight) stream into 4-lane groups for the PU and
// tracks, through a delay line, the cycle in which the PU result is valid.
module pu_feeder #(
    parameter int DATA_W     = 32,
    parameter int PU_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    pu_feeder_if.slave bus
);
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [1:0]               idx;
    logic signed [DATA_W-1:0] stg_a [3];
    logic signed [DATA_W-1:0] stg_w [3];
    logic signed [DATA_W-1:0] lane_a_p0 [4];
    logic signed [DATA_W-1:0] lane_w_p0 [4];
    logic                     vld_p0;
    logic                     last_p0;
    logic [PU_LATENCY-1:0]    vld_dly;
    logic [PU_LATENCY-1:0]    last_dly;
    logic                     fill_ready;
    logic                     accept;
    logic                     issue;
    logic                     res_last_int;

    // Lanes below the slot index come from staging, the slot lane takes the
    // incoming pair, and higher lanes are zeroed so they add nothing to the sum.
    function automatic logic signed [DATA_W-1:0] lane_sel(
        input logic [1:0]               lane,
        input logic [1:0]               cnt,
        input logic signed [DATA_W-1:0] staged,
        input logic signed [DATA_W-1:0] incoming
    );
        if (lane < cnt) begin
            return staged;
        end else if (lane == cnt) begin
            return incoming;
        end
        return '0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fill_ready = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        unique case (state)
            FILL: begin
                fill_ready = 1'b1;
                accept     = bus.in_valid;
                issue      = bus.in_valid && ((idx == 2'd3) || bus.in_last);
                if (issue && bus.in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (res_last_int) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Stage p0: staging slots and the registered PU operand lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                stg_a[i] <= '0;
                stg_w[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                lane_a_p0[i] <= '0;
                lane_w_p0[i] <= '0;
            end
        end else begin
            vld_p0  <= issue;
            last_p0 <= issue & bus.in_last;
            if (issue) begin
                idx <= '0;
                for (int j = 0; j < 3; j++) begin
                    lane_a_p0[j] <= lane_sel(2'(j), idx, stg_a[j], bus.in_a);
                    lane_w_p0[j] <= lane_sel(2'(j), idx, stg_w[j], bus.in_w);
                end
                lane_a_p0[3] <= lane_sel(2'd3, idx, '0, bus.in_a);
                lane_w_p0[3] <= lane_sel(2'd3, idx, '0, bus.in_w);
            end else if (accept) begin
                stg_a[idx] <= bus.in_a;
                stg_w[idx] <= bus.in_w;
                idx        <= idx + 2'd1;
            end
        end
    end

    // Stages p1..pN: valid/last follow the operands through the PU registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_dly  <= '0;
            last_dly <= '0;
        end else begin
            vld_dly[0]  <= vld_p0;
            last_dly[0] <= last_p0;
            for (int i = 1; i < PU_LATENCY; i++) begin
                vld_dly[i]  <= vld_dly[i-1];
                last_dly[i] <= last_dly[i-1];
            end
        end
    end

    assign res_last_int  = vld_dly[PU_LATENCY-1] & last_dly[PU_LATENCY-1];

    assign bus.in_ready  = fill_ready & rst;
    assign bus.a1        = lane_a_p0[0];
    assign bus.a2        = lane_a_p0[1];
    assign bus.a3        = lane_a_p0[2];
    assign bus.a4        = lane_a_p0[3];
    assign bus.w1        = lane_w_p0[0];
    assign bus.w2        = lane_w_p0[1];
    assign bus.w3        = lane_w_p0[2];
    assign bus.w4        = lane_w_p0[3];
    assign bus.pu_valid  = vld_p0;
    assign bus.pu_last   = last_p0;
    assign bus.res_valid = vld_dly[PU_LATENCY-1];
    assign bus.res_last  = res_last_int;
endmodule

// File: tb/tb_pu_feeder.sv
// Directed bench for pu_feeder with a small two-stage PU model supplying the sum
// that should be present whenever res_valid is raised.
module tb_pu_feeder;
    localparam int DATA_W     = 32;
    localparam int PU_LATENCY = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pu_feeder_if #(.DATA_W(DATA_W)) bus ();

    pu_feeder #(
        .DATA_W    (DATA_W),
        .PU_LATENCY(PU_LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // PU model: products at the first edge, sum at the second.
    logic signed [63:0] prod [4];
    logic signed [63:0] pu_sum;
    always @(posedge clk) begin
        prod[0] <= 64'(bus.a1) * 64'(bus.w1);
        prod[1] <= 64'(bus.a2) * 64'(bus.w2);
        prod[2] <= 64'(bus.a3) * 64'(bus.w3);
        prod[3] <= 64'(bus.a4) * 64'(bus.w4);
        pu_sum  <= prod[0] + prod[1] + prod[2] + prod[3];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int w, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = DATA_W'(a);
        bus.in_w     = DATA_W'(w);
        bus.in_last  = last;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    function automatic logic [127:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {32'(x0), 32'(x1), 32'(x2), 32'(x3)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = $urandom;
        bus.in_w     = $urandom;
        bus.in_last  = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 128'(bus.in_ready), 0);
        chk("rst_lanes", 128'(bus.a1 | bus.a2 | bus.a3 | bus.a4 | bus.w1 | bus.w2 | bus.w3 | bus.w4), 0);
        chk("rst_strobes", 128'({bus.pu_valid, bus.pu_last, bus.res_valid, bus.res_last}), 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 128'(bus.in_ready), 1);

        // Full group 1..4 / 5..8 closing a vector.
        for (int i = 0; i < 4; i++) begin
            drive(i + 1, i + 5, i == 3);
            step();
            if (i < 3) chk("fill_no_pu_valid", 128'(bus.pu_valid), 0);
        end
        chk("full_a", pack4(bus.a1, bus.a2, bus.a3, bus.a4), pack4(1, 2, 3, 4));
        chk("full_w", pack4(bus.w1, bus.w2, bus.w3, bus.w4), pack4(5, 6, 7, 8));
        chk("full_pu", 128'({bus.pu_valid, bus.pu_last, bus.in_ready}), 128'(3'b110));
        idle();
        step();
        chk("full_k2", 128'({bus.pu_valid, bus.in_ready, bus.res_valid}), 0);
        step();
        chk("full_res", 128'({bus.res_valid, bus.res_last, bus.in_ready}), 128'(3'b110));
        chk("full_sum", 128'(pu_sum), 70);
        step();
        chk("full_k4", 128'({bus.in_ready, bus.res_valid}), 128'(2'b10));

        // Partial group: two pairs, lanes 3/4 zeroed.
        drive(3, 2, 1'b0);
        step();
        drive(4, 1, 1'b1);
        step();
        chk("part_a", pack4(bus.a1, bus.a2, bus.a3, bus.a4), pack4(3, 4, 0, 0));
        chk("part_w", pack4(bus.w1, bus.w2, bus.w3, bus.w4), pack4(2, 1, 0, 0));
        chk("part_pu", 128'({bus.pu_valid, bus.pu_last}), 128'(2'b11));
        idle();
        step();
        step();
        chk("part_res", 128'({bus.res_valid, bus.res_last}), 128'(2'b11));
        chk("part_sum", 128'(pu_sum), 10);
        step();

        // Back-to-back: two groups with no bubbles.
        for (int i = 0; i < 8; i++) begin
            drive(i + 1, i + 1, i == 7);
            step();
            chk("b2b_pu_valid", 128'(bus.pu_valid), 128'((i == 3) || (i == 7)));
            chk("b2b_pu_last", 128'(bus.pu_last), 128'(i == 7));
            if (i < 7) chk("b2b_res", 128'({bus.res_valid, bus.res_last}), 128'((i == 5) ? 2'b10 : 2'b00));
            if (i == 5) chk("b2b_sum1", 128'(pu_sum), 30);
        end
        chk("b2b_drain_ready", 128'(bus.in_ready), 0);
        idle();
        step();
        chk("b2b_gap", 128'(bus.res_valid), 0);
        step();
        chk("b2b_res2", 128'({bus.res_valid, bus.res_last}), 128'(2'b11));
        chk("b2b_sum2", 128'(pu_sum), 174);
        step();

        // One-pair vector, then a pair held through DRAIN.
        drive(2, 3, 1'b1);
        step();
        chk("one_a", pack4(bus.a1, bus.a2, bus.a3, bus.a4), pack4(2, 0, 0, 0));
        chk("one_w", pack4(bus.w1, bus.w2, bus.w3, bus.w4), pack4(3, 0, 0, 0));
        chk("one_pu", 128'({bus.pu_valid, bus.pu_last}), 128'(2'b11));
        drive(5, 7, 1'b1);
        step();
        chk("stall_k2", 128'({bus.in_ready, bus.pu_valid}), 0);
        step();
        chk("stall_k3", 128'({bus.in_ready, bus.pu_valid, bus.res_valid, bus.res_last}), 128'(4'b0011));
        chk("one_sum", 128'(pu_sum), 6);
        step();
        chk("stall_k4", 128'({bus.in_ready, bus.pu_valid}), 128'(2'b10));
        step();
        chk("stall_take", 128'({bus.pu_valid, bus.pu_last}), 128'(2'b11));
        chk("stall_a", pack4(bus.a1, bus.a2, bus.a3, bus.a4), pack4(5, 0, 0, 0));
        chk("stall_w", pack4(bus.w1, bus.w2, bus.w3, bus.w4), pack4(7, 0, 0, 0));
        idle();
        step();
        step();
        chk("stall_res", 128'({bus.res_valid, bus.res_last}), 128'(2'b11));
        chk("stall_sum", 128'(pu_sum), 35);
        step();

        // Reset one cycle after pu_valid: the group must never be flagged.
        for (int i = 0; i < 4; i++) begin
            drive(i + 1, i + 1, i == 3);
            step();
        end
        chk("mid_pu_valid", 128'(bus.pu_valid), 1);
        idle();
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_out", 128'({bus.in_ready, bus.pu_valid, bus.res_valid, bus.res_last}), 0);
        chk("mid_rst_lanes", 128'(bus.a1 | bus.a4 | bus.w1 | bus.w4), 0);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rel_ready", 128'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_res", 128'(bus.res_valid), 0);
            step();
        end
        drive(6, 1, 1'b0);
        step();
        chk("post_no_pu1", 128'(bus.pu_valid), 0);
        drive(7, 1, 1'b0);
        step();
        chk("post_no_pu2", 128'(bus.pu_valid), 0);
        drive(8, 1, 1'b1);
        step();
        chk("post_a", pack4(bus.a1, bus.a2, bus.a3, bus.a4), pack4(6, 7, 8, 0));
        chk("post_pu", 128'({bus.pu_valid, bus.pu_last}), 128'(2'b11));
        idle();
        step();
        step();
        chk("post_res", 128'({bus.res_valid, bus.res_last}), 128'(2'b11));
        chk("post_sum", 128'(pu_sum), 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pu_feeder.md
# pu_feeder

Operand feeder that sits directly upstream of the 4-lane processing unit (four multipliers, adder tree, activation). It accepts a serial stream of (activation, weight) pairs and packs them into groups of four. Each group is presented to the PU's a1..a4 / w1..w4 inputs for exactly one cycle. A valid pipeline matched to the PU's two register stages marks the cycle in which the PU's `out` is meaningful, and the block drains the pipeline after each end-of-vector.

## Interface
Parameters:
- DATA_W, 32, width of activations, weights and PU lanes
- PU_LATENCY, 2, register stages inside the PU between operand inputs and `out`

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  pair on in_a/in_w is offered
- in_ready  out  1  feeder accepts a pair this cycle
- in_a  in  DATA_W  activation
- in_w  in  DATA_W  weight
- in_last  in  1  offered pair is the final pair of the vector
- a1, a2, a3, a4  out  DATA_W  PU activation lanes, registered
- w1, w2, w3, w4  out  DATA_W  PU weight lanes, registered
- pu_valid  out  1  lanes hold a new group this cycle
- pu_last  out  1  group in lanes closes a vector; only meaningful with pu_valid
- res_valid  out  1  PU `out` is the result of a group this cycle
- res_last  out  1  that result closes a vector

## Operation
- A pair is accepted on a rising edge when in_valid && in_ready.
- There is no backpressure from the PU. res_valid/res_last are strobes and consumers must sample them.
- Staging: 2-bit slot index `idx`, 0..3, and three staging pairs for slots 0..2.
- FSM states:
  - FILL: in_ready=1.
    - Accepted pair with idx<3 and !in_last: write the pair to slot idx, then idx++.
    - Accepted pair with idx==3 or in_last: **issue**.
      - Lanes 1..idx load from staging. Lane idx+1 loads the incoming pair. Remaining lanes load a=0, w=0, so they contribute nothing to the sum.
      - pu_valid=1 next cycle, and pu_last=in_last.
      - idx returns to 0.
      - If in_last, go to DRAIN; otherwise stay in FILL.
  - DRAIN: in_ready=0. Hold until the cycle res_last is asserted, then return to FILL on the following edge. in_ready=1 from that cycle.
- Lane registers hold their last values when pu_valid=0. pu_valid and pu_last are single-cycle pulses.
- Delay line: a PU_LATENCY-deep shift register carries {pu_valid, pu_last}. Its output drives res_valid/res_last.
- in_valid while in_ready=0 is ignored, with no state change. The source must hold the pair.
- Reset (rst=0, asynchronous):
  - All outputs go to 0: in_ready, a1..a4, w1..w4, pu_valid, pu_last, res_valid, res_last.
  - idx=0, staging cleared, delay line cleared, state=FILL.
  - The first in_ready=1 comes combinationally once rst=1.
- Reset mid-group or mid-drain discards the partial group and any in-flight valid bits. The PU's stale `out` is never flagged valid.

## Timing
- Pair accepted at edge k completes a group: lanes and pu_valid are valid in cycle k+1. The PU captures the products at edge k+1 and the sum at edge k+2.
- res_valid is high in cycle k+1+PU_LATENCY, which is cycle k+3 with the default latency. This cycle aligns with PU `out`.
- Full rate: one pair per cycle in FILL gives one group every 4 cycles. Back-to-back groups need no bubbles.
- DRAIN length after the edge accepting in_last: in_ready=0 for cycles k+1..k+1+PU_LATENCY, then 1 from cycle k+2+PU_LATENCY.
- A vector of one pair: an immediate issue with lanes 2..4 zero.
- A vector of exactly 4·n pairs: the last pair at idx==3 issues with no zero lanes.
- in_last at idx==3: a single issue, with no extra empty group.

## Test plan
- Reset: hold rst=0 with in_valid=1 and random data, then release. Required: all outputs 0 during reset, in_ready=1 after release, and no pu_valid until 4 pairs are accepted.
- Full group: stream a=1,2,3,4 and w=5,6,7,8 on consecutive cycles, with in_last on the 4th pair. Required:
  - cycle after the 4th accept: lanes a1..a4=1..4, w1..w4=5..8, pu_valid=pu_last=1 for one cycle;
  - 2 cycles later: res_valid=res_last=1 and PU sum 70;
  - in_ready=0 for 3 cycles after the last accept.
- Partial group: pairs (3,2) and (4,1) with in_last on the second. Required: a=3,4,0,0 and w=2,1,0,0, with PU sum 10 flagged by res_last.
- Back-to-back: 8 pairs with no gaps, in_last on the 8th. Required: pu_valid at cycles k+1 and k+5 with pu_last only on the second, and res_valid pulses 4 cycles apart.
- Stall in DRAIN: keep in_valid=1 during DRAIN with a new pair. Required: no acceptance. The pair is taken only in the first FILL cycle and lands in slot 0.
- Reset mid-drain: assert rst one cycle after pu_valid. Required: res_valid never asserts for that group, and the next vector behaves as after a cold reset.
